hazard_ctrl: RTL and testbench

//  Pipeline hazard/flow controller upstream of the ID-stage control mux. Generates Stall
//  (load-use bubble) and NOP (branch flush) for the ID mux, plus PC/IF-ID write enables and a

---
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use bubble, branch flush and bus-freeze control for the ID mux.
// Optional feature macro: HAZ_PERF_CNT_EN (stall/flush performance counters).
module hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rd_addr,
  input  logic             EX_branch_taken,
  input  logic             IM_stall,
  input  logic             DM_stall,
  output logic             Stall,
  output logic             NOP,
  output logic             IF_ID_flush,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cycle_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, BUBBLE} state_t;

  localparam logic [1:0] CNT_INIT = (LU_BUBBLES > 1) ? 2'(LU_BUBBLES - 2) : 2'd0;

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       flush_pending, flush_pending_n;
  logic       freeze, lu_hit, flush_req;

  assign freeze    = IM_stall | DM_stall;
  assign flush_req = EX_branch_taken | flush_pending;
  assign lu_hit    = EX_MemRead && (EX_rd_addr != 5'd0) &&
                     ((ID_use_rs1 && (ID_rs1_addr == EX_rd_addr)) ||
                      (ID_use_rs2 && (ID_rs2_addr == EX_rd_addr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      cnt           <= 2'd0;
      flush_pending <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      flush_pending <= flush_pending_n;
    end
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    flush_pending_n = flush_pending;
    Stall           = 1'b0;
    NOP             = 1'b0;
    IF_ID_flush     = 1'b0;
    PC_write        = 1'b1;
    IF_ID_write     = 1'b1;
    pipe_freeze     = 1'b0;
    if (rst) begin
      NOP         = 1'b1;
      IF_ID_flush = 1'b1;
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (freeze) begin
      // A redirect seen while frozen is replayed on the first free cycle.
      pipe_freeze = 1'b1;
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      if (EX_branch_taken) flush_pending_n = 1'b1;
    end else if (flush_req) begin
      NOP             = 1'b1;
      IF_ID_flush     = 1'b1;
      flush_pending_n = 1'b0;
      state_n         = RUN;
      cnt_n           = 2'd0;
    end else if (state == BUBBLE) begin
      Stall       = 1'b1;
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      if (cnt == 2'd0) state_n = RUN;
      else             cnt_n   = cnt - 2'd1;
    end else if (lu_hit) begin
      Stall       = 1'b1;
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      if (LU_BUBBLES > 1) begin
        state_n = BUBBLE;
        cnt_n   = CNT_INIT;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Stall and NOP are already forced low while frozen, so the counters hold then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycle_cnt <= '0;
      flush_cnt       <= '0;
    end else begin
      if (Stall) stall_cycle_cnt <= stall_cycle_cnt + 1'b1;
      if (NOP)   flush_cnt       <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cycle_cnt = '0;
  assign flush_cnt       = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven scoreboard bench for hazard_ctrl (LU_BUBBLES=1 and 3).
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       bt;
    logic       ims;
    logic       dms;
    logic       mr;
    logic [4:0] rd;
    logic       use1;
    logic [4:0] rs1;
    logic       use2;
    logic [4:0] rs2;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [5:0] e1;
    logic [5:0] e3;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] e1;
    logic [5:0] e3;
  } exp_t;

  // {Stall, NOP, IF_ID_flush, PC_write, IF_ID_write, pipe_freeze}
  localparam logic [5:0] NRM = 6'b000110;
  localparam logic [5:0] STL = 6'b100000;
  localparam logic [5:0] FLS = 6'b011110;
  localparam logic [5:0] FRZ = 6'b000001;
  localparam logic [5:0] RST = 6'b011001;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic use1, use2, mr, bt, ims, dms;
  logic stall1, nop1, iff1, pcw1, ifw1, frz1;
  logic stall3, nop3, iff3, pcw3, ifw3, frz3;
  logic [31:0] scnt1, fcnt1, scnt3, fcnt3;
  logic [5:0] o1, o3;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  assign o1 = {stall1, nop1, iff1, pcw1, ifw1, frz1};
  assign o3 = {stall3, nop3, iff3, pcw3, ifw3, frz3};

  hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst),
    .ID_rs1_addr(rs1), .ID_rs2_addr(rs2), .ID_use_rs1(use1), .ID_use_rs2(use2),
    .EX_MemRead(mr), .EX_rd_addr(rd), .EX_branch_taken(bt),
    .IM_stall(ims), .DM_stall(dms),
    .Stall(stall1), .NOP(nop1), .IF_ID_flush(iff1), .PC_write(pcw1),
    .IF_ID_write(ifw1), .pipe_freeze(frz1),
    .stall_cycle_cnt(scnt1), .flush_cnt(fcnt1)
  );

  hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(32)) u3 (
    .clk(clk), .rst(rst),
    .ID_rs1_addr(rs1), .ID_rs2_addr(rs2), .ID_use_rs1(use1), .ID_use_rs2(use2),
    .EX_MemRead(mr), .EX_rd_addr(rd), .EX_branch_taken(bt),
    .IM_stall(ims), .DM_stall(dms),
    .Stall(stall3), .NOP(nop3), .IF_ID_flush(iff3), .PC_write(pcw3),
    .IF_ID_write(ifw3), .pipe_freeze(frz3),
    .stall_cycle_cnt(scnt3), .flush_cnt(fcnt3)
  );

  function automatic in_t mk(logic r, logic b, logic i, logic d, logic m, logic [4:0] dst,
                             logic u1_, logic [4:0] s1, logic u2_, logic [4:0] s2);
    in_t t;
    t = '{rst: r, bt: b, ims: i, dms: d, mr: m, rd: dst, use1: u1_, rs1: s1, use2: u2_, rs2: s2};
    return t;
  endfunction

  task automatic add(string n, in_t in, logic [5:0] e1, logic [5:0] e3);
    vec_t v;
    v.name = n; v.in = in; v.e1 = e1; v.e3 = e3;
    vecs.push_back(v);
  endtask

  task automatic drive(in_t in);
    rst = in.rst; bt = in.bt; ims = in.ims; dms = in.dms; mr = in.mr;
    rd = in.rd; use1 = in.use1; rs1 = in.rs1; use2 = in.use2; rs2 = in.rs2;
  endtask

  task automatic check_cnt(string n, logic [31:0] got);
    checks++;
    if (got !== 32'd0) begin
      errors++;
      $display("FAIL %s got %0d want 0", n, got);
    end
  endtask

  initial begin
    in_t idle, haz, hbr, frb, b_frz, rdz, nuse, nmr, hit1;
    exp_t e;
    idle  = mk(0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    haz   = mk(0, 0, 0, 0, 1, 5'd5, 0, 5'd1, 1, 5'd5);
    hbr   = mk(0, 1, 0, 0, 1, 5'd5, 0, 5'd1, 1, 5'd5);
    frb   = mk(0, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    b_frz = mk(0, 1, 0, 1, 1, 5'd5, 0, 5'd1, 1, 5'd5);
    rdz   = mk(0, 0, 0, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0);
    nuse  = mk(0, 0, 0, 0, 1, 5'd7, 0, 5'd7, 0, 5'd0);
    nmr   = mk(0, 0, 0, 0, 0, 5'd7, 1, 5'd7, 0, 5'd0);
    hit1  = mk(0, 0, 0, 0, 1, 5'd7, 1, 5'd7, 0, 5'd0);

    add("reset",        mk(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0), RST, RST);
    add("idle",         idle, NRM, NRM);
    add("lu_rs2",       haz,  STL, STL);
    add("lu_after1",    idle, NRM, STL);
    add("lu_after2",    idle, NRM, STL);
    add("lu_done",      idle, NRM, NRM);
    add("lu3_first",    haz,  STL, STL);
    for (int k = 0; k < 4; k++)
      add("lu3_dm_frz", mk(0, 0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0), FRZ, FRZ);
    add("lu3_second",   idle, NRM, STL);
    add("lu3_third",    idle, NRM, STL);
    add("lu3_done",     idle, NRM, NRM);
    add("br_over_lu",   hbr,  FLS, FLS);
    add("br_next",      idle, NRM, NRM);
    add("abort_start",  haz,  STL, STL);
    add("abort_br",     frb ^ mk(0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0), FLS, FLS);
    add("abort_next",   idle, NRM, NRM);
    add("im_br",        frb,  FRZ, FRZ);
    add("im_hold",      mk(0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0), FRZ, FRZ);
    add("im_release",   idle, FLS, FLS);
    add("im_after",     idle, NRM, NRM);
    add("rd_zero",      rdz,  NRM, NRM);
    add("no_use",       nuse, NRM, NRM);
    add("no_memread",   nmr,  NRM, NRM);
    add("lu_rs1",       hit1, STL, STL);
    add("lu_rs1_b2",    idle, NRM, STL);
    add("lu_rs1_b3",    idle, NRM, STL);
    add("lu_rs1_done",  idle, NRM, NRM);
    add("frz_over_br",  b_frz, FRZ, FRZ);
    add("frz_br_late",  idle, FLS, FLS);
    add("frz_br_next",  idle, NRM, NRM);
    add("rst_bub_st",   haz,  STL, STL);
    add("rst_mid_bub",  mk(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0), RST, RST);
    add("rst_bub_rel",  idle, NRM, NRM);
    add("rst_frz_br",   frb,  FRZ, FRZ);
    add("rst_mid_frz",  mk(1, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0), RST, RST);
    add("rst_frz_rel",  idle, NRM, NRM);
    add("rst_frz_rel2", idle, NRM, NRM);

    drive(vecs[0].in);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].in);
      e.name = vecs[i].name; e.e1 = vecs[i].e1; e.e3 = vecs[i].e3;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      checks++;
      if (o1 !== e.e1) begin
        errors++;
        $display("FAIL %s lu1 got %b want %b", e.name, o1, e.e1);
      end
      checks++;
      if (o3 !== e.e3) begin
        errors++;
        $display("FAIL %s lu3 got %b want %b", e.name, o3, e.e3);
      end
      if (i == 1) begin
        check_cnt("cnt_reset_stall1", scnt1);
        check_cnt("cnt_reset_flush3", fcnt3);
      end
    end
    check_cnt("cnt_after_rst_stall1", scnt1);
    check_cnt("cnt_after_rst_flush1", fcnt1);
    check_cnt("cnt_after_rst_stall3", scnt3);
    check_cnt("cnt_after_rst_flush3", fcnt3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
